cam_capture: RTL and testbench

Camera-side writer for the frame buffer: samples an OV7670-style parallel pixel bus (PCLK, VSYNC, HREF, D[7:0]) carrying RGB565, converts each pixel to RGB332 and writes it into the write port of the dual-port buffer RAM, which the VGA path reads. Sits between the camera connector pins and `buffer_ram_dp` (`clk_w` side) in the camera top level, clocked by the board clock.

---
 rtl/cam_capture_pkg.sv | 26 ++
 rtl/cam_sync.sv | 42 ++++
 rtl/cam_capture.sv | 127 ++++++++++++
 tb/tb_cam_capture.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cam_capture_pkg.sv
// rtl/cam_capture_pkg.sv - shared frame-buffer geometry, colours and capture types
// Used by the camera writer and the VGA-side reader.
package cam_capture_pkg;

    localparam int CAM_SCREEN_X = 160;   // pixels per stored line
    localparam int CAM_SCREEN_Y = 120;   // stored lines per frame
    localparam int AW           = 15;    // buffer address width, ceil(log2(X*Y+1))
    localparam int DW           = 8;     // buffer data width (RGB332)

    localparam logic [DW-1:0] RED_VGA   = 8'hE0;
    localparam logic [DW-1:0] GREEN_VGA = 8'h1C;
    localparam logic [DW-1:0] BLUE_VGA  = 8'h03;

    typedef enum logic [1:0] {
        WAIT_FRAME,
        WAIT_LINE,
        BYTE_HI,
        BYTE_LO
    } cap_state_t;

    // hi = R4..R0 G5..G3, lo = G2..G0 B4..B0; keep the top bits of each channel
    function automatic logic [DW-1:0] rgb565_to_332(input logic [7:0] hi, input logic [7:0] lo);
        return {hi[7:5], hi[2:0], lo[4:3]};
    endfunction

endpackage

// File: rtl/cam_sync.sv
// rtl/cam_sync.sv - two-flop synchronizer for the camera bus plus pclk rise detect
// Ports:
//   clk, rst                      board clock, async active-low reset
//   cam_pclk/vsync/href/data      raw camera pins
//   vsync_s, href_s, data_s       synchronized, aligned with the pclk stage
//   pclk_rise                     one-clk pulse marking a sample cycle
module cam_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic       cam_pclk,
    input  logic       cam_vsync,
    input  logic       cam_href,
    input  logic [7:0] cam_data,
    output logic       vsync_s,
    output logic       href_s,
    output logic [7:0] data_s,
    output logic       pclk_rise
);

    // All eleven bits travel together so data/href/vsync line up with pclk.
    logic [10:0] stage1;
    logic [10:0] stage2;
    logic        pclk_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage1 <= '0;
            stage2 <= '0;
            pclk_q <= 1'b0;
        end else begin
            stage1 <= {cam_pclk, cam_vsync, cam_href, cam_data};
            stage2 <= stage1;
            pclk_q <= stage2[10];
        end
    end

    assign pclk_rise = stage2[10] & ~pclk_q;
    assign vsync_s   = stage2[9];
    assign href_s    = stage2[8];
    assign data_s    = stage2[7:0];

endmodule

// File: rtl/cam_capture.sv
// rtl/cam_capture.sv - OV7670 RGB565 capture into the RGB332 frame buffer write port
// Ports:
//   clk, rst                      board clock (also RAM write clock), async active-low reset
//   cam_pclk/vsync/href/data      camera parallel bus
//   mem_addr, mem_data, mem_we    buffer write port, one-clk strobe per pixel
//   frame_done                    one-clk pulse at end of a captured frame
//   frame_err                     last frame was malformed; held until next frame_done
module cam_capture
    import cam_capture_pkg::*;
#(
    parameter int SCREEN_X = CAM_SCREEN_X,
    parameter int SCREEN_Y = CAM_SCREEN_Y,
    parameter int ADDR_W   = AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cam_pclk,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DW-1:0]     mem_data,
    output logic              mem_we,
    output logic              frame_done,
    output logic              frame_err
);

    localparam logic [ADDR_W-1:0] PIX_TOTAL = ADDR_W'(SCREEN_X * SCREEN_Y);
    localparam logic [ADDR_W-1:0] CNT_MAX   = '1;

    logic       vsync_s;
    logic       href_s;
    logic [7:0] data_s;
    logic       pclk_rise;

    cam_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .cam_pclk  (cam_pclk),
        .cam_vsync (cam_vsync),
        .cam_href  (cam_href),
        .cam_data  (cam_data),
        .vsync_s   (vsync_s),
        .href_s    (href_s),
        .data_s    (data_s),
        .pclk_rise (pclk_rise)
    );

    cap_state_t        state;
    logic [ADDR_W-1:0] pix_cnt;
    logic [7:0]        hi_byte;
    logic              vsync_q;
    logic              err_flag;
    logic              vs_rise;
    logic              vs_fall;

    // vsync history only advances on sample cycles, so edges are seen on sample cycles
    assign vs_rise = vsync_s & ~vsync_q;
    assign vs_fall = ~vsync_s & vsync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= WAIT_FRAME;
            pix_cnt    <= '0;
            hi_byte    <= '0;
            vsync_q    <= 1'b0;
            err_flag   <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            mem_we     <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            mem_we     <= 1'b0;
            frame_done <= 1'b0;
            if (pclk_rise) begin
                vsync_q <= vsync_s;
                if (state == WAIT_FRAME) begin
                    if (vs_fall) begin
                        state    <= WAIT_LINE;
                        pix_cnt  <= '0;
                        mem_addr <= '0;
                        err_flag <= 1'b0;
                    end
                end else if (vs_rise) begin
                    // a high byte still waiting for its partner is an aborted pixel
                    frame_done <= 1'b1;
                    frame_err  <= err_flag | (state == BYTE_LO) | (pix_cnt != PIX_TOTAL);
                    err_flag   <= 1'b0;
                    state      <= WAIT_FRAME;
                end else begin
                    case (state)
                        WAIT_LINE, BYTE_HI: begin
                            if (href_s) begin
                                hi_byte <= data_s;
                                state   <= BYTE_LO;
                            end else begin
                                state   <= WAIT_LINE;
                            end
                        end
                        BYTE_LO: begin
                            if (href_s) begin
                                // address X*Y stays untouched for the reader's border colour
                                if (pix_cnt < PIX_TOTAL) begin
                                    mem_we   <= 1'b1;
                                    mem_addr <= pix_cnt;
                                    mem_data <= rgb565_to_332(hi_byte, data_s);
                                end else begin
                                    err_flag <= 1'b1;
                                end
                                if (pix_cnt != CNT_MAX) begin
                                    pix_cnt <= pix_cnt + ADDR_W'(1);
                                end
                                state <= BYTE_HI;
                            end else begin
                                err_flag <= 1'b1;
                                state    <= WAIT_LINE;
                            end
                        end
                        default: state <= WAIT_FRAME;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_cam_capture.sv
// tb/tb_cam_capture.sv - scoreboard bench for cam_capture on a reduced frame size
module tb_cam_capture;

    localparam int X     = 20;
    localparam int Y     = 15;
    localparam int AWB   = 9;
    localparam int TOTAL = X * Y;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           cam_pclk = 1'b0;
    logic           cam_vsync = 1'b0;
    logic           cam_href = 1'b0;
    logic [7:0]     cam_data = 8'h00;
    logic [AWB-1:0] mem_addr;
    logic [7:0]     mem_data;
    logic           mem_we;
    logic           frame_done;
    logic           frame_err;

    cam_capture #(
        .SCREEN_X (X),
        .SCREEN_Y (Y),
        .ADDR_W   (AWB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cam_pclk   (cam_pclk),
        .cam_vsync  (cam_vsync),
        .cam_href   (cam_href),
        .cam_data   (cam_data),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_we     (mem_we),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;
    initial begin
        #3;
        forever #20 cam_pclk = ~cam_pclk;
    end

    typedef struct {
        logic [AWB-1:0] a;
        logic [7:0]     d;
    } wr_t;

    wr_t  wq[$];
    logic dq[$];

    int total_cnt = 0;
    int bad_cnt   = 0;

    bit m_active = 0;
    bit m_err    = 0;
    bit m_hi     = 0;
    int m_count  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    logic prev_we   = 1'b0;
    logic prev_done = 1'b0;

    always @(negedge clk) begin
        wr_t  e;
        logic fe;
        if (mem_we) begin
            check("we_width", prev_we, 0);
            check("we_expected", wq.size() > 0, 1);
            if (wq.size() > 0) begin
                e = wq.pop_front();
                check("addr", mem_addr, e.a);
                check("data", mem_data, e.d);
            end
        end
        if (frame_done) begin
            check("done_width", prev_done, 0);
            check("done_expected", dq.size() > 0, 1);
            if (dq.size() > 0) begin
                fe = dq.pop_front();
                check("frame_err", frame_err, fe);
            end
        end
        prev_we   = mem_we;
        prev_done = frame_done;
    end

    task automatic drive_byte(input logic [7:0] b);
        @(negedge cam_pclk);
        cam_href = 1'b1;
        cam_data = b;
    endtask

    task automatic drive_pixel(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] e);
        drive_byte(hi);
        drive_byte(lo);
        if (m_active) begin
            if (m_count < TOTAL) wq.push_back('{a: AWB'(m_count), d: e});
            else m_err = 1;
            m_count++;
        end
    endtask

    task automatic end_line();
        @(negedge cam_pclk);
        cam_href = 1'b0;
        cam_data = 8'($urandom);
        if (m_active && m_hi) m_err = 1;
        m_hi = 0;
        repeat (3) @(negedge cam_pclk);
    endtask

    task automatic vs_rise();
        @(negedge cam_pclk);
        cam_href  = 1'b0;
        cam_vsync = 1'b1;
        if (m_active) begin
            dq.push_back(m_err || m_hi || (m_count != TOTAL));
            m_active = 0;
        end
        repeat (4) @(negedge cam_pclk);
    endtask

    task automatic vs_fall();
        @(negedge cam_pclk);
        cam_vsync = 1'b0;
        m_active  = 1;
        m_count   = 0;
        m_err     = 0;
        m_hi      = 0;
        repeat (4) @(negedge cam_pclk);
    endtask

    task automatic do_reset();
        @(negedge cam_pclk);
        cam_href = 1'b0;
        repeat (3) @(negedge cam_pclk);
        @(negedge clk);
        rst      = 1'b0;
        m_active = 0;
        m_hi     = 0;
        @(negedge clk);
        check("rst_mid_we", mem_we, 0);
        check("rst_mid_addr", mem_addr, 0);
        check("rst_mid_err", frame_err, 0);
        check("rst_mid_pending", wq.size(), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // mode 0: all red; mode 1: green, blue, then random pixels
    task automatic send_frame(input int lines, input int odd_line, input int mode, input int rst_pix);
        logic [7:0] hi, lo, e;
        for (int l = 0; l < lines; l++) begin
            for (int p = 0; p < X; p++) begin
                if (rst_pix >= 0 && m_active && m_count == rst_pix) do_reset();
                if (mode == 0) begin
                    hi = 8'hF8; lo = 8'h00; e = 8'hE0;
                end else if (l == 0 && p == 0) begin
                    hi = 8'h07; lo = 8'hE0; e = 8'h1C;
                end else if (l == 0 && p == 1) begin
                    hi = 8'h00; lo = 8'h1F; e = 8'h03;
                end else begin
                    hi = 8'($urandom);
                    lo = 8'($urandom);
                    e  = {hi[7:5], hi[2:0], lo[4:3]};
                end
                drive_pixel(hi, lo, e);
            end
            if (l == odd_line) begin
                drive_byte(8'($urandom));
                m_hi = m_active;
            end
            end_line();
        end
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_addr", mem_addr, 0);
        check("rst_data", mem_data, 0);
        check("rst_we", mem_we, 0);
        check("rst_done", frame_done, 0);
        check("rst_err", frame_err, 0);
        rst = 1'b1;

        // bytes before any vsync falling edge must be ignored
        for (int i = 0; i < 12; i++) drive_byte(8'($urandom));
        end_line();
        vs_rise();
        vs_fall();

        send_frame(Y, -1, 0, -1);       // full red frame
        vs_rise(); vs_fall();
        send_frame(Y, -1, 1, -1);       // green, blue, random
        vs_rise(); vs_fall();
        send_frame(Y, 3, 1, -1);        // one line with an odd byte count
        vs_rise(); vs_fall();
        send_frame(Y + 1, -1, 1, -1);   // one line too many
        vs_rise(); vs_fall();
        send_frame(Y, -1, 1, 100);      // reset mid-frame, rest ignored
        vs_rise(); vs_fall();
        send_frame(Y, -1, 0, -1);       // clean frame after reset
        vs_rise();

        for (int i = 0; i < 400 && (wq.size() != 0 || dq.size() != 0); i++) @(negedge clk);
        repeat (50) @(negedge clk);
        check("wq_left", wq.size(), 0);
        check("dq_left", dq.size(), 0);
        check("err_hold", frame_err, 0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
